// File: rtl/bus_router_pkg.sv
// Shared types and constants for the CPU bus router and its address decoder.
package bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Target index: 0..7 are peripheral slots, the rest are special codes.
  localparam int TARGET_W = 4;
  typedef logic [TARGET_W-1:0] target_t;

  localparam target_t TARGET_RAM  = 4'd8;
  localparam target_t TARGET_NONE = 4'd15;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Convert a one-hot slot vector into a slot index; lowest set bit wins.
  function automatic target_t onehot_to_target(input logic [7:0] oh);
    target_t idx;
    idx = TARGET_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) idx = target_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address map: peripheral slots first, then RAM, else unmapped.
module bus_addr_decoder
  import bus_router_pkg::*;
#(
  parameter int                         NUM_PERIPH  = 2,
  parameter logic [NUM_PERIPH*32-1:0]   PERIPH_BASE = {32'h2000_0004, 32'h2000_0000},
  parameter logic [NUM_PERIPH*32-1:0]   PERIPH_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFFC},
  parameter logic [31:0]                RAM_BYTES   = 32'h0001_0000
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_PERIPH-1:0] slot_oh_o,
  output logic                  is_ram_o,
  output logic                  is_unmapped_o
);

  logic [NUM_PERIPH-1:0] match;
  logic                  any_match;
  logic                  below_ram;

  // One comparator per slot against its masked base.
  for (genvar gi = 0; gi < NUM_PERIPH; gi++) begin : g_match
    assign match[gi] = ((addr_i & PERIPH_MASK[32*gi +: 32]) == PERIPH_BASE[32*gi +: 32]);
  end

  // Isolate the lowest matching slot so overlapping windows resolve by index.
  always_comb begin
    slot_oh_o     = match & (~match + NUM_PERIPH'(1));
    any_match     = |match;
    below_ram     = (addr_i < RAM_BYTES);
    is_ram_o      = !any_match && below_ram;
    is_unmapped_o = !any_match && !below_ram;
  end

endmodule

// File: rtl/bus_router.sv
// Registered router from the PicoRV32 native port to RAM and peripheral slots,
// with per-access timeout and unmapped-address error response.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int                         NUM_PERIPH     = 2,
  parameter logic [NUM_PERIPH*32-1:0]   PERIPH_BASE    = {32'h2000_0004, 32'h2000_0000},
  parameter logic [NUM_PERIPH*32-1:0]   PERIPH_MASK    = {32'hFFFF_FFFC, 32'hFFFF_FFFC},
  parameter logic [31:0]                RAM_BYTES      = 32'h0001_0000,
  parameter int unsigned                TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // CPU native port
  input  logic                     cpu_valid_i,
  output logic                     cpu_ready_o,
  input  logic [31:0]              cpu_addr_i,
  input  logic [31:0]              cpu_wdata_i,
  input  logic [3:0]               cpu_wstrb_i,
  output logic [31:0]              cpu_rdata_o,
  // RAM port
  output logic                     mem_valid_o,
  input  logic                     mem_ready_i,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [3:0]               mem_wstrb_o,
  input  logic [31:0]              mem_rdata_i,
  // Peripheral slots
  output logic [NUM_PERIPH-1:0]    per_valid_o,
  input  logic [NUM_PERIPH-1:0]    per_ready_i,
  output logic [31:0]              per_addr_o,
  output logic [31:0]              per_wdata_o,
  output logic [3:0]               per_wstrb_o,
  input  logic [NUM_PERIPH*32-1:0] per_rdata_i,
  // Error reporting
  output logic                     err_o,
  output logic [31:0]              err_addr_o,
  input  logic                     err_clr_i
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  target_t               target_q, target_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [NUM_PERIPH-1:0] per_valid_q, per_valid_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           err_addr_q, err_addr_d;

  logic [NUM_PERIPH-1:0] dec_slot_oh;
  logic                  dec_is_ram;
  logic                  dec_is_unmapped;
  logic [7:0]            slot_oh_ext;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  err_evt;

  bus_addr_decoder #(
    .NUM_PERIPH  (NUM_PERIPH),
    .PERIPH_BASE (PERIPH_BASE),
    .PERIPH_MASK (PERIPH_MASK),
    .RAM_BYTES   (RAM_BYTES)
  ) u_dec (
    .addr_i        (cpu_addr_i),
    .slot_oh_o     (dec_slot_oh),
    .is_ram_o      (dec_is_ram),
    .is_unmapped_o (dec_is_unmapped)
  );

  // Widen the slot vector so the package helper can turn it into an index.
  always_comb begin
    slot_oh_ext                 = '0;
    slot_oh_ext[NUM_PERIPH-1:0] = dec_slot_oh;
  end

  // Pick ready and read data of the target latched for this access.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    if (target_q == TARGET_RAM) begin
      sel_ready = mem_ready_i;
      sel_rdata = mem_rdata_i;
    end
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (target_q == target_t'(i)) begin
        sel_ready = per_ready_i[i];
        sel_rdata = per_rdata_i[32*i +: 32];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/REQ/RESP handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    per_valid_d = per_valid_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    err_addr_d  = err_addr_q;
    err_evt     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cpu_valid_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          if (dec_is_unmapped) begin
            // No target to wait for: answer the CPU on the very next cycle.
            target_d    = TARGET_NONE;
            cpu_ready_d = 1'b1;
            cpu_rdata_d = ERR_RDATA;
            err_evt     = 1'b1;
            err_addr_d  = cpu_addr_i;
            state_d     = ST_RESP;
          end else begin
            target_d    = dec_is_ram ? TARGET_RAM : onehot_to_target(slot_oh_ext);
            mem_valid_d = dec_is_ram;
            per_valid_d = dec_is_ram ? '0 : dec_slot_oh;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (sel_ready) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = sel_rdata;
          mem_valid_d = 1'b0;
          per_valid_d = '0;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Target held valid for the full budget without answering.
          cpu_ready_d = 1'b1;
          cpu_rdata_d = ERR_RDATA;
          mem_valid_d = 1'b0;
          per_valid_d = '0;
          err_evt     = 1'b1;
          err_addr_d  = addr_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear.
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      target_q    <= TARGET_NONE;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      per_valid_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      per_valid_q <= per_valid_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign cpu_ready_o = cpu_ready_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign per_valid_o = per_valid_q;
  assign per_addr_o  = addr_q;
  assign per_wdata_o = wdata_q;
  assign per_wstrb_o = wstrb_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: directed table, hand sequences, random traffic.
module tb_bus_router;

  localparam int          TMO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_ni;
  logic        cpu_valid_i;
  logic        cpu_ready_o;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_wstrb_i;
  logic [31:0] cpu_rdata_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic [1:0]  per_valid_o;
  logic [1:0]  per_ready_i;
  logic [31:0] per_addr_o;
  logic [31:0] per_wdata_o;
  logic [3:0]  per_wstrb_o;
  logic [63:0] per_rdata_i;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_clr_i;

  int n_cmp = 0;
  int n_mis = 0;

  // Bench's own view of the sticky error state.
  logic        model_err      = 1'b0;
  logic [31:0] model_err_addr = 32'h0;

  bus_router #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cpu_valid_i (cpu_valid_i),
    .cpu_ready_o (cpu_ready_o),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_wstrb_i (cpu_wstrb_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_rdata_i (mem_rdata_i),
    .per_valid_o (per_valid_o),
    .per_ready_i (per_ready_i),
    .per_addr_o  (per_addr_o),
    .per_wdata_o (per_wdata_o),
    .per_wstrb_o (per_wstrb_o),
    .per_rdata_i (per_rdata_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_clr_i   (err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Address map as ranges: 0 = slot0, 1 = slot1, 2 = RAM, 3 = unmapped.
  function automatic int ref_target(input logic [31:0] a);
    if (a >= 32'h2000_0000 && a <= 32'h2000_0003) return 0;
    if (a >= 32'h2000_0004 && a <= 32'h2000_0007) return 1;
    if (a < 32'h0001_0000) return 2;
    return 3;
  endfunction

  // Expected outcome from target kind and response delay.
  task automatic model_txn(input int tgt, input int delay, input logic [31:0] tdata,
                           output int rc, output int vc, output logic [31:0] rd, output bit err);
    if (tgt == 3) begin
      rc = 1; vc = 0; rd = ERR; err = 1'b1;
    end else if (delay < TMO) begin
      rc = delay + 2; vc = delay + 1; rd = tdata; err = 1'b0;
    end else begin
      rc = TMO + 1; vc = TMO; rd = ERR; err = 1'b1;
    end
  endtask

  // Drive one CPU access from an idle negedge; the selected target answers
  // 'delay' cycles after its valid rises, the others toggle ready randomly.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int tgt, input int delay,
                         input logic [31:0] tdata, input int exp_rc, input int exp_vc,
                         input logic [31:0] exp_rd, input bit exp_err);
    int          rc, vc, rise, extra, wrong_v, bus_bad;
    logic [31:0] rd, eaddr_seen, e_err_addr;
    logic        err_seen, sel_v, oth_v, e_err;
    rc = 0; vc = 0; rise = -1; extra = 0; wrong_v = 0; bus_bad = 0;
    rd = '0; eaddr_seen = '0; err_seen = 1'b0;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_wstrb_i = wstrb;
    cpu_valid_i = 1'b1;
    mem_rdata_i = (tgt == 2) ? tdata : $urandom();
    per_rdata_i[31:0]  = (tgt == 0) ? tdata : $urandom();
    per_rdata_i[63:32] = (tgt == 1) ? tdata : $urandom();
    mem_ready_i = 1'b0;
    per_ready_i = 2'b00;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      sel_v = (tgt == 2 && mem_valid_o) || (tgt == 0 && per_valid_o[0]) || (tgt == 1 && per_valid_o[1]);
      oth_v = (tgt != 2 && mem_valid_o) || (tgt != 0 && per_valid_o[0]) || (tgt != 1 && per_valid_o[1]);
      if (sel_v) begin
        vc++;
        if (rise < 0) rise = c;
        if (mem_addr_o !== addr || per_addr_o !== addr || mem_wdata_o !== wdata ||
            per_wdata_o !== wdata || mem_wstrb_o !== wstrb || per_wstrb_o !== wstrb)
          bus_bad++;
      end
      if (oth_v) wrong_v++;
      if (cpu_ready_o) begin
        if (rc == 0) begin
          rc = c; rd = cpu_rdata_o; err_seen = err_o; eaddr_seen = err_addr_o;
          cpu_valid_i = 1'b0;
        end else begin
          extra++;
        end
      end else if (rc != 0) begin
        break;
      end
      mem_ready_i    = (tgt == 2) ? (rise >= 0 && c >= rise + delay) : 1'($urandom_range(0, 1));
      per_ready_i[0] = (tgt == 0) ? (rise >= 0 && c >= rise + delay) : 1'($urandom_range(0, 1));
      per_ready_i[1] = (tgt == 1) ? (rise >= 0 && c >= rise + delay) : 1'($urandom_range(0, 1));
    end
    cpu_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    per_ready_i = 2'b00;
    e_err      = model_err | exp_err;
    e_err_addr = exp_err ? addr : model_err_addr;
    check({tag, ".ready_cycle"}, 32'(rc), 32'(exp_rc));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".valid_cycles"}, 32'(vc), 32'(exp_vc));
    check({tag, ".extra_ready"}, 32'(extra), 32'd0);
    check({tag, ".wrong_valid"}, 32'(wrong_v), 32'd0);
    check({tag, ".bus"}, 32'(bus_bad), 32'd0);
    check({tag, ".err"}, {31'b0, err_seen}, {31'b0, e_err});
    check({tag, ".err_addr"}, eaddr_seen, e_err_addr);
    model_err      = e_err;
    model_err_addr = e_err_addr;
    $display("txn %-14s addr=%h tgt=%0d delay=%0d ready@%0d rdata=%h err=%0b",
             tag, addr, tgt, delay, rc, rd, err_seen);
  endtask

  task automatic pulse_clr(input string tag);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check({tag, ".err_cleared"}, {31'b0, err_o}, 32'd0);
    check({tag, ".err_addr_kept"}, err_addr_o, model_err_addr);
    model_err = 1'b0;
    $display("txn %-14s err_clr -> err=%0b err_addr=%h", tag, err_o, err_addr_o);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          tgt;
    int          delay;
    logic [31:0] tdata;
    int          exp_rc;
    int          exp_vc;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          rc, vc, tgt, delay;
    logic [31:0] rd, addr, tdata;
    bit          err;
    logic        ready_seen;

    vecs[0] = '{"ram_read",   32'h0000_0100, 32'h0, 4'h0, 2, 2,   32'h1234_5678, 4, 3, 32'h1234_5678, 1'b0};
    vecs[1] = '{"p0_write",   32'h2000_0000, 32'hFF, 4'hF, 0, 0,  32'h0000_0011, 2, 1, 32'h0000_0011, 1'b0};
    vecs[2] = '{"p1_read",    32'h2000_0004, 32'h0, 4'h0, 1, 1,   32'h0000_00A5, 3, 2, 32'h0000_00A5, 1'b0};
    vecs[3] = '{"ram_top_lst",32'h0000_FFFC, 32'h0, 4'h0, 2, 3,   32'hCAFE_0001, 5, 4, 32'hCAFE_0001, 1'b0};
    vecs[4] = '{"p0_alias",   32'h2000_0003, 32'h55, 4'h1, 0, 0,  32'h0000_5A5A, 2, 1, 32'h0000_5A5A, 1'b0};
    vecs[5] = '{"unmapped",   32'h4000_0000, 32'h0, 4'h0, 3, 0,   32'h0,         1, 0, ERR,           1'b1};
    vecs[6] = '{"ram_end",    32'h0001_0000, 32'h0, 4'h0, 3, 0,   32'h0,         1, 0, ERR,           1'b1};
    vecs[7] = '{"timeout",    32'h0000_0200, 32'h0, 4'h0, 2, 100, 32'h1111_2222, 5, 4, ERR,           1'b1};
    vecs[8] = '{"periph_gap", 32'h2000_0008, 32'h0, 4'h0, 3, 0,   32'h0,         1, 0, ERR,           1'b1};

    rst_ni = 1'b0; cpu_valid_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0; per_ready_i = '0; per_rdata_i = '0; err_clr_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.cpu_ready", {31'b0, cpu_ready_o}, 32'd0);
    check("reset.valids", {29'b0, mem_valid_o, per_valid_o}, 32'd0);
    check("reset.cpu_rdata", cpu_rdata_o, 32'd0);
    check("reset.addr_bus", mem_addr_o | per_addr_o, 32'd0);
    check("reset.err", {31'b0, err_o}, 32'd0);
    check("reset.err_addr", err_addr_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].name, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].tgt,
              vecs[i].delay, vecs[i].tdata, vecs[i].exp_rc, vecs[i].exp_vc,
              vecs[i].exp_rd, vecs[i].exp_err);
    end

    pulse_clr("clr_after_err");

    // Error and clear on the same edge: the flag must stay set.
    cpu_addr_i = 32'h4000_0010; cpu_valid_i = 1'b1; err_clr_i = 1'b1;
    @(negedge clk);
    check("err_vs_clr.ready", {31'b0, cpu_ready_o}, 32'd1);
    check("err_vs_clr.err", {31'b0, err_o}, 32'd1);
    check("err_vs_clr.err_addr", err_addr_o, 32'h4000_0010);
    cpu_valid_i = 1'b0; err_clr_i = 1'b0;
    model_err = 1'b1; model_err_addr = 32'h4000_0010;
    @(negedge clk);
    check("err_vs_clr.ready_drop", {31'b0, cpu_ready_o}, 32'd0);
    $display("txn %-14s addr=%h err=%0b err_addr=%h", "err_vs_clr", 32'h4000_0010, err_o, err_addr_o);

    // Reset in the middle of a RAM access.
    cpu_addr_i = 32'h0000_0300; cpu_valid_i = 1'b1; mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid.valid_before", {31'b0, mem_valid_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid.valids", {29'b0, mem_valid_o, per_valid_o}, 32'd0);
    check("rst_mid.cpu_ready", {31'b0, cpu_ready_o}, 32'd0);
    check("rst_mid.addr_bus", mem_addr_o | per_addr_o, 32'd0);
    check("rst_mid.err", {31'b0, err_o}, 32'd0);
    check("rst_mid.err_addr", err_addr_o, 32'd0);
    check("rst_mid.cpu_rdata", cpu_rdata_o, 32'd0);
    cpu_valid_i = 1'b0;
    ready_seen = 1'b0;
    repeat (2) begin @(negedge clk); ready_seen |= cpu_ready_o; end
    rst_ni = 1'b1;
    repeat (3) begin @(negedge clk); ready_seen |= cpu_ready_o; end
    check("rst_mid.no_ready", {31'b0, ready_seen}, 32'd0);
    model_err = 1'b0; model_err_addr = 32'h0;
    $display("txn %-14s addr=%h aborted ready_seen=%0b", "rst_mid", 32'h0000_0300, ready_seen);
    run_txn("after_reset", 32'h0000_0040, 32'h0, 4'h0, 2, 1, 32'h0BAD_F00D, 3, 2, 32'h0BAD_F00D, 1'b0);

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom_range(0, 32'h0000_FFFF) & 32'hFFFF_FFFC;
        1:       addr = 32'h2000_0000 + $urandom_range(0, 3);
        2:       addr = 32'h2000_0004 + $urandom_range(0, 3);
        default: addr = $urandom();
      endcase
      delay = $urandom_range(0, 6);
      tdata = $urandom();
      tgt   = ref_target(addr);
      model_txn(tgt, delay, tdata, rc, vc, rd, err);
      run_txn($sformatf("rand%0d", n), addr, $urandom(), 4'($urandom()), tgt, delay, tdata,
              rc, vc, rd, err);
      if ((n % 8) == 7 && model_err) pulse_clr($sformatf("rand_clr%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
